// File: rtl/fire8_pkg.sv
`default_nettype none
// fire8_pkg: shared fire8 geometry constants and the OFM writer state encoding.
package fire8_pkg;

  localparam int FIRE8_WIDTH      = 16;
  localparam int FIRE8_WOUT       = 8;
  localparam int FIRE8_CH_TOTAL   = 512;
  localparam int FIRE8_E1_CH_BASE = 0;
  localparam int FIRE8_E3_CH_BASE = 256;
  localparam int FIRE8_E1_DSP_NO  = 256;
  localparam int FIRE8_LANES      = 4;

  typedef enum logic [1:0] {
    WR_IDLE  = 2'd0,
    WR_DRAIN = 2'd1,
    WR_DONE  = 2'd2
  } wr_state_e;

endpackage
`default_nettype wire

// File: rtl/fire8_expand1_ofm_writer.sv
`default_nettype none
// fire8_expand1_ofm_writer: captures the expand1 channel vector and drains it as LANES-wide RAM words.
// Optional macro FIRE8_WR_OVF_CHECK_EN adds the sticky ovf_err_o flag.
module fire8_expand1_ofm_writer
  import fire8_pkg::*;
#(
  parameter int WIDTH    = FIRE8_WIDTH,
  parameter int DSP_NO   = FIRE8_E1_DSP_NO,
  parameter int LANES    = FIRE8_LANES,
  parameter int WOUT     = FIRE8_WOUT,
  parameter int CH_TOTAL = FIRE8_CH_TOTAL,
  parameter int CH_BASE  = FIRE8_E1_CH_BASE,
  parameter int ADDR_W   = $clog2(WOUT*WOUT*CH_TOTAL/LANES)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sample_i,
  input  logic [WIDTH-1:0]       ofm_i [DSP_NO],
  output logic                   wr_en_o,
  output logic [ADDR_W-1:0]      wr_addr_o,
  output logic [LANES*WIDTH-1:0] wr_data_o,
  output logic                   busy_o,
  output logic                   layer_done_o
`ifdef FIRE8_WR_OVF_CHECK_EN
  ,
  output logic                   ovf_err_o
`endif
);

  localparam int GROUPS = DSP_NO / LANES;
  localparam int PIXELS = WOUT * WOUT;
  localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int PW     = (PIXELS > 1) ? $clog2(PIXELS) : 1;
  localparam int IW     = (DSP_NO > 1) ? $clog2(DSP_NO) : 1;
  localparam int WPP    = CH_TOTAL / LANES;
  localparam int BASE_W = CH_BASE / LANES;
  localparam logic [GW-1:0] G_LAST = GW'(GROUPS - 1);
  localparam logic [PW-1:0] P_LAST = PW'(PIXELS - 1);

  wr_state_e        r_state;
  logic [GW-1:0]    r_g;
  logic [PW-1:0]    r_p;
  logic [WIDTH-1:0] r_shadow [DSP_NO];

  logic                   w_drain;
  logic                   w_last_grp;
  logic                   w_last_pix;
  logic                   w_accept;
  logic [GW-1:0]          w_g_nxt;
  logic [PW-1:0]          w_p_acc;
  logic [LANES*WIDTH-1:0] w_lane_word;

  function automatic logic [ADDR_W-1:0] word_addr(input logic [PW-1:0] pix);
    return ADDR_W'(int'(pix) * WPP + BASE_W);
  endfunction

  assign w_drain    = (r_state == WR_DRAIN);
  assign w_last_grp = (r_g == G_LAST);
  assign w_last_pix = (r_p == P_LAST);
  // A sample on the final group of the final pixel is ignored so p can never wrap.
  assign w_accept   = sample_i && ((r_state == WR_IDLE) ||
                                   (w_drain && w_last_grp && !w_last_pix));
  assign w_p_acc    = w_drain ? (r_p + PW'(1)) : r_p;
  assign w_g_nxt    = r_g + GW'(1);

  always_comb begin
    w_lane_word = '0;
    for (int l = 0; l < LANES; l++) begin
      w_lane_word[l*WIDTH +: WIDTH] = r_shadow[IW'(int'(w_g_nxt) * LANES + l)];
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_shadow <= ofm_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= WR_IDLE;
      r_g          <= '0;
      r_p          <= '0;
      wr_en_o      <= 1'b0;
      wr_addr_o    <= '0;
      wr_data_o    <= '0;
      busy_o       <= 1'b0;
      layer_done_o <= 1'b0;
    end else begin
      layer_done_o <= 1'b0;
      if (w_accept) begin
        // Group 0 goes straight from the input so the first word lands one cycle after the sample.
        r_state   <= WR_DRAIN;
        r_g       <= '0;
        r_p       <= w_p_acc;
        wr_en_o   <= 1'b1;
        busy_o    <= 1'b1;
        wr_addr_o <= word_addr(w_p_acc);
        for (int l = 0; l < LANES; l++) begin
          wr_data_o[l*WIDTH +: WIDTH] <= ofm_i[l];
        end
      end else if (w_drain) begin
        if (!w_last_grp) begin
          r_g       <= w_g_nxt;
          wr_addr_o <= wr_addr_o + ADDR_W'(1);
          wr_data_o <= w_lane_word;
        end else begin
          wr_en_o <= 1'b0;
          busy_o  <= 1'b0;
          if (w_last_pix) begin
            r_state      <= WR_DONE;
            layer_done_o <= 1'b1;
          end else begin
            r_state <= WR_IDLE;
            r_p     <= r_p + PW'(1);
          end
        end
      end
    end
  end

`ifdef FIRE8_WR_OVF_CHECK_EN
  logic w_ovf;
  assign w_ovf = sample_i && w_drain && !w_last_grp;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_err_o <= 1'b0;
    end else if (w_ovf) begin
      ovf_err_o <= 1'b1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fire8_expand1_ofm_writer.sv
`default_nettype none
// tb_fire8_expand1_ofm_writer: scoreboard plus vector-table bench for the fire8 expand1 OFM writer.
module tb_fire8_expand1_ofm_writer;
  import fire8_pkg::*;

  localparam int W  = 16;
  localparam int N  = 256;
  localparam int L  = 4;
  localparam int G  = 64;
  localparam int AW = 13;

  typedef struct packed {
    logic [AW-1:0]  addr;
    logic [L*W-1:0] data;
  } wr_t;

  typedef struct {
    int             mode;
    logic [L*W-1:0] exp_w0;
    logic [AW-1:0]  exp_addr;
  } vec_t;

  logic           clk = 1'b0;
  logic           rst;
  logic           sample_i = 1'b0;
  logic           sample2  = 1'b0;
  logic [W-1:0]   ofm  [N];
  logic [W-1:0]   ofm2 [N];
  logic           wr_en_o, busy_o, layer_done_o;
  logic [AW-1:0]  wr_addr_o;
  logic [L*W-1:0] wr_data_o;
  logic           wr_en2, busy2, ld2;
  logic [AW-1:0]  addr2;
  logic [L*W-1:0] data2;
`ifdef FIRE8_WR_OVF_CHECK_EN
  logic           ovf_err_o, ovf2;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int t_acc, t_last;
  int busy_cnt, ld_cnt, ld_cyc, ld_overlap;
  int first_addr, cnt2, first2, last2;
  logic [L*W-1:0] first_data, w0_2;
  bit grab_first = 1'b0;
  wr_t sb[$];
  wr_t e_mon;
  vec_t tbl[6];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  fire8_expand1_ofm_writer dut (
    .clk(clk), .rst(rst), .sample_i(sample_i), .ofm_i(ofm),
    .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
    .busy_o(busy_o), .layer_done_o(layer_done_o)
`ifdef FIRE8_WR_OVF_CHECK_EN
    , .ovf_err_o(ovf_err_o)
`endif
  );

  fire8_expand1_ofm_writer #(.CH_BASE(256)) dut_off (
    .clk(clk), .rst(rst), .sample_i(sample2), .ofm_i(ofm2),
    .wr_en_o(wr_en2), .wr_addr_o(addr2), .wr_data_o(data2),
    .busy_o(busy2), .layer_done_o(ld2)
`ifdef FIRE8_WR_OVF_CHECK_EN
    , .ovf_err_o(ovf2)
`endif
  );

  always @(negedge clk) begin
    if (busy_o) busy_cnt++;
    if (layer_done_o) begin
      ld_cnt++;
      ld_cyc = cyc;
      if (wr_en_o) ld_overlap++;
    end
    if (wr_en_o) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_write: got addr=%0d data=%h, expected no write", wr_addr_o, wr_data_o);
      end else begin
        e_mon = sb.pop_front();
        if (e_mon.addr !== wr_addr_o || e_mon.data !== wr_data_o) begin
          n_errors++;
          $display("FAIL write: got addr=%0d data=%h, expected addr=%0d data=%h",
                   wr_addr_o, wr_data_o, e_mon.addr, e_mon.data);
        end
      end
      if (grab_first) begin
        first_addr = int'(wr_addr_o);
        first_data = wr_data_o;
        grab_first = 1'b0;
      end
    end
    if (wr_en2) begin
      if (cnt2 == 0) begin
        first2 = int'(addr2);
        w0_2   = data2;
      end
      last2 = int'(addr2);
      cnt2++;
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic fill(input int mode, input int p);
    for (int c = 0; c < N; c++) begin
      case (mode)
        0:       ofm[c] = 16'(p * 256 + c);
        1:       ofm[c] = 16'hFFFF;
        2:       ofm[c] = 16'(65535 - c);
        3:       ofm[c] = (c % 2 == 0) ? 16'hA5A5 : 16'h5A5A;
        default: ofm[c] = 16'h0000;
      endcase
    end
  endtask

  task automatic push_pixel(input int p);
    wr_t e;
    for (int g = 0; g < G; g++) begin
      e.addr = AW'(p * 128 + g);
      for (int l = 0; l < L; l++) e.data[l*W +: W] = ofm[g*L + l];
      sb.push_back(e);
    end
  endtask

  task automatic pulse_sample();
    @(posedge clk); #1 sample_i = 1'b1;
    @(posedge clk); #1 sample_i = 1'b0;
    t_acc = cyc;
  endtask

  task automatic wait_drain(input string name);
    for (int k = 0; k < 300 && sb.size() != 0; k++) @(posedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL %s_timeout: got %0d words pending, expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    tbl[0] = '{mode: 0, exp_w0: 64'h0003_0002_0001_0000, exp_addr: 13'd0};
    tbl[1] = '{mode: 1, exp_w0: 64'hFFFF_FFFF_FFFF_FFFF, exp_addr: 13'd128};
    tbl[2] = '{mode: 2, exp_w0: 64'hFFFC_FFFD_FFFE_FFFF, exp_addr: 13'd256};
    tbl[3] = '{mode: 3, exp_w0: 64'h5A5A_A5A5_5A5A_A5A5, exp_addr: 13'd384};
    tbl[4] = '{mode: 4, exp_w0: 64'h0000_0000_0000_0000, exp_addr: 13'd512};
    tbl[5] = '{mode: 0, exp_w0: 64'h0503_0502_0501_0500, exp_addr: 13'd640};
    busy_cnt = 0; ld_cnt = 0; ld_cyc = 0; ld_overlap = 0; cnt2 = 0;
    fill(4, 0);
    for (int c = 0; c < N; c++) ofm2[c] = 16'(c);

    rst = 1'b1;
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_wr_en", 64'(wr_en_o), 64'd0);
    chk("reset_wr_addr", 64'(wr_addr_o), 64'd0);
    chk("reset_wr_data", wr_data_o, 64'd0);
    chk("reset_busy", 64'(busy_o), 64'd0);
    chk("reset_layer_done", 64'(layer_done_o), 64'd0);
`ifdef FIRE8_WR_OVF_CHECK_EN
    chk("reset_ovf", 64'(ovf_err_o), 64'd0);
`endif
    @(negedge clk) rst = 1'b1;

    // Offset slice on the second instance
    @(posedge clk); #1 sample2 = 1'b1;
    @(posedge clk); #1 sample2 = 1'b0;
    repeat (70) @(posedge clk);
    chk("offset_count", 64'(cnt2), 64'd64);
    chk("offset_first_addr", 64'(first2), 64'd64);
    chk("offset_last_addr", 64'(last2), 64'd127);
    chk("offset_word0", w0_2, 64'h0003_0002_0001_0000);

    // Single pixels from the vector table
    for (int i = 0; i < 6; i++) begin
      fill(tbl[i].mode, i);
      push_pixel(i);
      busy_cnt = 0;
      grab_first = 1'b1;
      pulse_sample();
      wait_drain("table");
      repeat (3) @(posedge clk);
      chk("table_word0", first_data, tbl[i].exp_w0);
      chk("table_addr0", 64'(first_addr), 64'(tbl[i].exp_addr));
      chk("table_busy_cycles", 64'(busy_cnt), 64'd64);
      chk("table_no_layer_done", 64'(ld_cnt), 64'd0);
    end

    // Back-to-back: second sample on the group-63 cycle
    busy_cnt = 0;
    fill(0, 6);
    push_pixel(6);
    pulse_sample();
    repeat (62) @(posedge clk);
    fill(0, 7);
    push_pixel(7);
    pulse_sample();
    chk("b2b_accept_cycle", 64'(t_acc - cyc), 64'd0);
    wait_drain("b2b");
    repeat (3) @(posedge clk);
    chk("b2b_busy_cycles", 64'(busy_cnt), 64'd128);

    // Overflow: second vector mid-drain is dropped
    fill(0, 8);
    push_pixel(8);
    pulse_sample();
    repeat (8) @(posedge clk);
`ifdef FIRE8_WR_OVF_CHECK_EN
    chk("ovf_before", 64'(ovf_err_o), 64'd0);
`endif
    fill(1, 0);
    pulse_sample();
`ifdef FIRE8_WR_OVF_CHECK_EN
    chk("ovf_set", 64'(ovf_err_o), 64'd1);
`endif
    wait_drain("ovf");
    repeat (3) @(posedge clk);
    chk("ovf_busy_low", 64'(busy_o), 64'd0);

    // Rest of the layer at the upstream cadence
    for (int p = 9; p < 64; p++) begin
      fill(0, p);
      push_pixel(p);
      pulse_sample();
      if (p == 63) t_last = t_acc;
      repeat (111) @(posedge clk);
    end
    wait_drain("layer");
    chk("layer_done_count", 64'(ld_cnt), 64'd1);
    chk("layer_done_cycle", 64'(ld_cyc - t_last), 64'd64);
    chk("layer_done_wr_en_low", 64'(ld_overlap), 64'd0);

    // Samples in DONE are ignored
    busy_cnt = 0;
    fill(1, 0);
    pulse_sample();
    repeat (80) @(posedge clk);
    chk("done_ignore_busy", 64'(busy_cnt), 64'd0);
    chk("done_ignore_layer_done", 64'(ld_cnt), 64'd1);

    // Mid-drain asynchronous reset, then restart at address 0
    @(negedge clk) rst = 1'b0;
    @(negedge clk) rst = 1'b1;
    fill(2, 0);
    push_pixel(0);
    pulse_sample();
    repeat (19) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("midrst_wr_en", 64'(wr_en_o), 64'd0);
    chk("midrst_wr_addr", 64'(wr_addr_o), 64'd0);
    chk("midrst_wr_data", wr_data_o, 64'd0);
    chk("midrst_busy", 64'(busy_o), 64'd0);
    sb.delete();
    @(negedge clk) rst = 1'b1;
    fill(0, 0);
    push_pixel(0);
    grab_first = 1'b1;
    pulse_sample();
    wait_drain("restart");
    repeat (3) @(posedge clk);
    chk("restart_addr0", 64'(first_addr), 64'd0);
    chk("restart_word0", first_data, 64'h0003_0002_0001_0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fire8_expand1_ofm_writer.md
# fire8_expand1_ofm_writer

Output-side stage placed directly after the fire8 expand1 convolution core. It captures the core's 256-channel parallel output vector on each sample pulse, drains it into the fire8 output feature-map RAM as LANES-wide words over consecutive cycles, and signals layer completion back upstream as the RAM feedback. Because CH_TOTAL and CH_BASE are parameters, the writer can place expand1 channels at any offset in the concatenated fire8 output alongside expand3.

## Interface
- WIDTH, 16, bits per activation
- DSP_NO, 256, channels per sample vector (upstream MAC count)
- LANES, 4, activations per RAM word; DSP_NO, CH_TOTAL and CH_BASE are all multiples of LANES
- WOUT, 8, output spatial dimension; WOUT**2 pixels per layer
- CH_TOTAL, 512, channels per pixel in the concatenated RAM layout
- CH_BASE, 0, first channel index of this writer's slice
- ADDR_W, $clog2(WOUT**2*CH_TOTAL/LANES), RAM word-address width (13 at defaults)

- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- sample_i  in  1  one-cycle pulse; ofm_i valid in the same cycle
- ofm_i  in  [WIDTH-1:0] x DSP_NO  unpacked channel vector, index 0 = channel CH_BASE
- wr_en_o  out  1  RAM write strobe
- wr_addr_o  out  ADDR_W  RAM word address
- wr_data_o  out  LANES*WIDTH  lane 0 in bits [WIDTH-1:0]
- busy_o  out  1  high in DRAIN
- layer_done_o  out  1  one-cycle pulse after the last word of the last pixel is written; drives upstream ram_feedback
- ovf_err_o  out  1  sticky overflow flag; present only with FIRE8_WR_OVF_CHECK_EN

## Operation
- GROUPS = DSP_NO/LANES (64 at defaults).
- States:
  - IDLE: accepted sample -> DRAIN.
  - DRAIN: accepted sample stays in DRAIN and restarts group 0 on the new vector; otherwise last group of last pixel -> DONE; otherwise last group -> IDLE.
  - DONE: terminal until reset.
- An accepted sample copies ofm_i into a shadow register (DSP_NO x WIDTH) and clears the group counter g.
- Each DRAIN cycle writes one word:
  - wr_data = shadow[g*LANES +: LANES]
  - wr_addr = p*(CH_TOTAL/LANES) + CH_BASE/LANES + g
  - p = pixel counter 0..WOUT**2-1; p increments after the last group of each pixel.
- Acceptance: sample_i is accepted in IDLE, and also in DRAIN on the cycle g == GROUPS-1. This gives back-to-back pixels with no gap.
- Sample_i in DRAIN with g < GROUPS-1 is an overflow. The new vector is dropped and the current drain completes unchanged.
- Sample_i in DONE is ignored.
- Data is written unmodified. No saturation or ReLU is applied here; upstream already clamps.
- Reset mid-operation: all counters and state return to their reset values immediately. The partial pixel is abandoned, and the RAM contents are left as written.

## Timing
- Reset values: wr_en_o=0, wr_addr_o=0, wr_data_o=0, busy_o=0, layer_done_o=0, ovf_err_o=0, state IDLE, p=0, g=0.
- All outputs are registered.
- Sample at cycle t: words are written at cycles t+1 .. t+GROUPS, with busy_o high over the same span.
- Upstream delivers a sample every 113 cycles (112 channels + 1), which gives a minimum margin of 113-GROUPS cycles at defaults.
- layer_done_o is high at cycle t_last+GROUPS+1, where t_last is the final pixel's sample, for exactly one cycle. wr_en_o=0 on that cycle.
- No address wrap: p never exceeds WOUT**2-1 because DONE blocks further samples.

## Configuration
- FIRE8_WR_OVF_CHECK_EN
  - Defined: ovf_err_o exists and sets on any overflow sample, holding until reset.
  - Undefined: the port and its logic are removed; overflow samples are still silently dropped.

## Structure
- Shared package fire8_pkg:
  - WIDTH and the fire8 geometry constants (WOUT, CH_TOTAL, expand1/expand3 CH_BASE values).
  - The writer state enum typedef (IDLE, DRAIN, DONE).
- The module is flat; the lane-select mux is inline. No sub-module is needed.

## Test plan
All scenarios use defaults.
- Single pixel: reset, sample with ofm_i[c]=c. -> 64 writes at t+1..t+64; addr 0..63; word 0 = {3,2,1,0}; busy_o high for 64 cycles; no layer_done_o.
- Full layer: 64 samples every 113 cycles with ofm_i[c]=p*256+c. -> 4096 writes; pixel 5 group 0 at addr 640; one layer_done_o pulse exactly 65 cycles after the last sample.
- Back-to-back: a second sample on the cycle of group 63. -> the next pixel's group 0 write follows immediately, with busy_o never low in between.
- Overflow: a second sample at t+10. -> the drain continues with the original data, the second vector never appears on wr_data_o, and ovf_err_o=1 from t+11 (macro defined).
- Offset slice: CH_BASE=256, one sample. -> first address 64, last address 127.
- Mid-drain reset: rst low at t+20. -> all outputs 0 asynchronously; after release, a new sample writes starting at addr 0.
